// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
// Multicycle 32-bit MIPS-subset core. It runs from one shared, word-addressed
// memory over a bidirectional bus. The memory is expected to return read data
// combinationally in the same cycle and to commit writes at the rising edge.
//
// Ports:
//   CLK      - rising-edge clock
//   RST      - synchronous active-high reset; also masks CS/WE in the cycle it is high
//   CS       - memory chip select (FETCH and MEM states)
//   WE       - memory write enable (MEM state of sw only)
//   Address  - word address: PC on fetch, ALUOut on load/store
//   Mem_Bus  - shared data bus; driven with B only while WE=1, released otherwise
module mips_multicycle_core #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              CS,
    output logic              WE,
    output logic [ADDR_W-1:0] Address,
    inout  wire  [DATA_W-1:0] Mem_Bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                           OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                           OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03,
                           FN_JR  = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22,
                           FN_AND = 6'h24, FN_OR  = 6'h25, FN_XOR = 6'h26,
                           FN_SLT = 6'h2A;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   imm_s_q, imm_s_d;
    logic [DATA_W-1:0]   imm_z_q, imm_z_d;
    logic [4:0]          shamt_q, shamt_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [DATA_W-1:0]   regs_q [32];

    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic                cs, we;
    logic [ADDR_W-1:0]   addr;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];

    // Bus strobes are masked by RST so that a reset arriving mid-store
    // cannot let the memory commit at the closing edge.
    assign CS      = cs & ~RST;
    assign WE      = we & ~RST;
    assign Address = RST ? '0 : addr;
    assign Mem_Bus = WE ? b_q : 'z;

    // Next-state, datapath and bus control, decoded from the current state.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_s_d  = imm_s_q;
        imm_z_d  = imm_z_q;
        shamt_d  = shamt_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = alu_q;
        cs       = 1'b0;
        we       = 1'b0;
        addr     = '0;

        case (state_q)
            S_FETCH: begin
                cs      = 1'b1;
                addr    = pc_q[ADDR_W-1:0];
                ir_d    = Mem_Bus;
                pc_d    = pc_q + DATA_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d     = (rs == 5'd0) ? '0 : regs_q[rs];
                b_d     = (rt == 5'd0) ? '0 : regs_q[rt];
                imm_s_d = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
                imm_z_d = {{(DATA_W-16){1'b0}}, ir_q[15:0]};
                shamt_d = ir_q[10:6];
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                // Anything not recognised below falls back to FETCH as a NOP.
                state_d = S_FETCH;
                case (opcode)
                    OP_RTYPE: begin
                        state_d = S_WRITEBACK;
                        case (funct)
                            FN_ADD: alu_d = a_q + b_q;
                            FN_SUB: alu_d = a_q - b_q;
                            FN_AND: alu_d = a_q & b_q;
                            FN_OR:  alu_d = a_q | b_q;
                            FN_XOR: alu_d = a_q ^ b_q;
                            FN_SLT: alu_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                            FN_SLL: alu_d = b_q << shamt_q;
                            FN_SRL: alu_d = b_q >> shamt_q;
                            FN_SRA: alu_d = $signed(b_q) >>> shamt_q;
                            FN_JR: begin
                                pc_d    = a_q;
                                state_d = S_FETCH;
                            end
                            default: state_d = S_FETCH;
                        endcase
                    end
                    OP_ADDI: begin alu_d = a_q + imm_s_q; state_d = S_WRITEBACK; end
                    OP_ANDI: begin alu_d = a_q & imm_z_q; state_d = S_WRITEBACK; end
                    OP_ORI:  begin alu_d = a_q | imm_z_q; state_d = S_WRITEBACK; end
                    OP_SLTI: begin
                        alu_d   = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(imm_s_q))};
                        state_d = S_WRITEBACK;
                    end
                    OP_LUI:  begin alu_d = imm_z_q << 16; state_d = S_WRITEBACK; end
                    // pc_q already points past the branch, so the offset is
                    // relative to the following instruction.
                    OP_BEQ:  if (a_q == b_q) pc_d = pc_q + imm_s_q;
                    OP_BNE:  if (a_q != b_q) pc_d = pc_q + imm_s_q;
                    OP_J:    pc_d = {pc_q[DATA_W-1:26], ir_q[25:0]};
                    OP_JAL: begin
                        rf_we    = 1'b1;
                        rf_waddr = 5'd31;
                        rf_wdata = pc_q;
                        pc_d     = {pc_q[DATA_W-1:26], ir_q[25:0]};
                    end
                    OP_LW, OP_SW: begin
                        alu_d   = a_q + imm_s_q;
                        state_d = S_MEM;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                cs   = 1'b1;
                addr = alu_q[ADDR_W-1:0];
                if (opcode == OP_SW) begin
                    we      = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    mdr_d   = Mem_Bus;
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                rf_we    = 1'b1;
                rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
                rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State and datapath registers; the register file never stores into R0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_s_q <= '0;
            imm_z_q <= '0;
            shamt_q <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_s_q <= imm_s_d;
            imm_z_q <= imm_z_d;
            shamt_q <= shamt_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            if (rf_we && rf_waddr != 5'd0) regs_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core
// Directed bench for mips_multicycle_core. It owns a 128-word memory
// (combinational read, write at posedge), loads a small program per scenario
// while the core is in reset, and checks the bus traffic seen at negedge.
module tb_mips_multicycle_core;

   localparam logic [31:0] IDLE = 32'hA5A5_5A5A;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   wire         CS;
   wire         WE;
   wire  [6:0]  Address;
   wire  [31:0] Mem_Bus;

   logic [31:0] mem [0:127];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int weGlitch = 0;
   int busErr = 0;

   int          rdCycQ [$];
   logic [6:0]  rdAddrQ [$];
   logic [6:0]  stAddrQ [$];
   logic [31:0] stDataQ [$];

   mips_multicycle_core #(.ADDR_W(7), .DATA_W(32)) dut (
      .CLK(CLK),
      .RST(RST),
      .CS(CS),
      .WE(WE),
      .Address(Address),
      .Mem_Bus(Mem_Bus)
   );

   always #5 CLK = ~CLK;

   // Memory side of the bus: read data when selected, an idle pattern when
   // deselected, and hands off the bus whenever the core writes.
   assign Mem_Bus = WE ? 32'bz : (CS ? mem[Address] : IDLE);

   always @(posedge CLK) begin
      cyc++;
      if (CS && WE) mem[Address] = Mem_Bus;
   end

   // Bus monitor: logs reads and stores, and flags strobes or bus values
   // that a well-behaved core never produces.
   always @(negedge CLK) begin
      if (WE && !CS) weGlitch++;
      if (!CS && !WE && Mem_Bus !== IDLE) busErr++;
      if (!RST) begin
         if (CS && !WE) begin
            rdCycQ.push_back(cyc);
            rdAddrQ.push_back(Address);
         end
         if (CS && WE) begin
            stAddrQ.push_back(Address);
            stDataQ.push_back(Mem_Bus);
         end
      end
   end

   function automatic logic [31:0] encR(int rs, int rt, int rd, int sh, int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction

   function automatic logic [31:0] encI(int op, int rs, int rt, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] encJ(int op, int target);
      return {6'(op), 26'(target)};
   endfunction

   // Puts the core into reset, clears memory and the logs.
   task automatic hold_reset();
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      for (int i = 0; i < 128; i++) mem[i] = 32'd0;
      rdCycQ.delete();
      rdAddrQ.delete();
      stAddrQ.delete();
      stDataQ.delete();
   endtask

   task automatic release_reset();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   task automatic run_cycles(int n);
      repeat (n) @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic test_reset();
      hold_reset();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (CS !== 1'b0) begin failures++; $display("[TB] FAIL reset_cs got=%b exp=0", CS); end
      checks++;
      if (WE !== 1'b0) begin failures++; $display("[TB] FAIL reset_we got=%b exp=0", WE); end
      checks++;
      if (Mem_Bus !== IDLE) begin failures++; $display("[TB] FAIL reset_bus_released got=%h exp=%h", Mem_Bus, IDLE); end
      @(posedge CLK);
      #1;
      RST = 1'b0;
      @(negedge CLK);
      checks++;
      if (CS !== 1'b1 || Address !== 7'd0 || WE !== 1'b0)
         begin failures++; $display("[TB] FAIL first_fetch got cs=%b addr=%h we=%b exp cs=1 addr=00 we=0", CS, Address, WE); end
   endtask

   task automatic test_alu();
      logic [31:0] expD [6];
      logic [31:0] got;
      logic [6:0]  gotA;
      expD = '{32'd6, 32'd18, 32'd24, 32'd12, 32'd2, 32'd22};
      hold_reset();
      mem[0]  = encI('h08, 0, 1, 6);
      mem[1]  = encI('h2B, 0, 1, 'h41);
      mem[2]  = encI('h08, 0, 2, 18);
      mem[3]  = encI('h2B, 0, 2, 'h42);
      mem[4]  = encR(1, 2, 3, 0, 'h20);
      mem[5]  = encI('h2B, 0, 3, 'h43);
      mem[6]  = 32'h0041_2022;
      mem[7]  = encI('h2B, 0, 4, 'h44);
      mem[8]  = encI('h0C, 2, 5, 2);
      mem[9]  = encI('h2B, 0, 5, 'h45);
      mem[10] = encR(1, 2, 6, 0, 'h25);
      mem[11] = encI('h2B, 0, 6, 'h46);
      mem[12] = encJ('h02, 12);
      release_reset();
      run_cycles(80);
      checks++;
      if (stDataQ.size() != 6) begin failures++; $display("[TB] FAIL alu_store_count got=%0d exp=6", stDataQ.size()); end
      for (int i = 0; i < 6; i++) begin
         got  = (i < stDataQ.size()) ? stDataQ[i] : 32'hDEAD_0000;
         gotA = (i < stAddrQ.size()) ? stAddrQ[i] : 7'h00;
         checks++;
         if (got !== expD[i] || gotA !== 7'(8'h41 + i))
            begin failures++; $display("[TB] FAIL alu_store%0d got=%h@%h exp=%h@%h", i, got, gotA, expD[i], 7'(8'h41 + i)); end
      end
      checks++;
      if (mem[7'h46] !== 32'd22) begin failures++; $display("[TB] FAIL alu_mem_commit got=%h exp=16", mem[7'h46]); end
   endtask

   task automatic test_slt_shift();
      logic [31:0] expD [9];
      logic [31:0] got;
      int          regs [9];
      expD = '{32'd1, 32'h120, 32'd3, 32'hFFFF_FFFC, 32'd1, 32'd0, 32'h1234_8001, 32'd20, 32'h0000_FFF8};
      regs = '{7, 8, 9, 12, 13, 14, 15, 16, 17};
      hold_reset();
      mem[0]  = encI('h08, 0, 1, 6);
      mem[1]  = encI('h08, 0, 2, 18);
      mem[2]  = encR(1, 2, 3, 0, 'h20);
      mem[3]  = encR(1, 2, 7, 0, 'h2A);
      mem[4]  = encR(0, 2, 8, 4, 'h00);
      mem[5]  = encR(0, 3, 9, 3, 'h02);
      mem[6]  = encI('h08, 0, 11, -8);
      mem[7]  = encR(0, 11, 12, 1, 'h03);
      mem[8]  = encR(11, 1, 13, 0, 'h2A);
      mem[9]  = encI('h0A, 1, 14, -1);
      mem[10] = encI('h0F, 0, 15, 'h1234);
      mem[11] = encI('h0D, 15, 15, 'h8001);
      mem[12] = encR(1, 2, 16, 0, 'h26);
      mem[13] = encI('h0C, 11, 17, 'hFFFF);
      for (int i = 0; i < 9; i++) mem[14 + i] = encI('h2B, 0, regs[i], 'h47 + i);
      mem[23] = encJ('h02, 23);
      release_reset();
      run_cycles(140);
      checks++;
      if (stDataQ.size() != 9) begin failures++; $display("[TB] FAIL shift_store_count got=%0d exp=9", stDataQ.size()); end
      for (int i = 0; i < 9; i++) begin
         got = (i < stDataQ.size()) ? stDataQ[i] : 32'hDEAD_0000;
         checks++;
         if (got !== expD[i]) begin failures++; $display("[TB] FAIL shift_store_r%0d got=%h exp=%h", regs[i], got, expD[i]); end
      end
   endtask

   task automatic test_load();
      logic [6:0] expA [4];
      logic [6:0] gotA;
      expA = '{7'd0, 7'd3, 7'd1, 7'd2};
      hold_reset();
      mem[0] = encI('h23, 0, 10, 3);
      mem[1] = encI('h2B, 0, 10, 'h50);
      mem[2] = encJ('h02, 2);
      mem[3] = 32'h0041_2022;
      release_reset();
      run_cycles(30);
      for (int i = 0; i < 4; i++) begin
         gotA = (i < rdAddrQ.size()) ? rdAddrQ[i] : 7'h7F;
         checks++;
         if (gotA !== expA[i]) begin failures++; $display("[TB] FAIL load_read%0d got=%h exp=%h", i, gotA, expA[i]); end
      end
      checks++;
      if (rdCycQ.size() < 4 || rdCycQ[2] - rdCycQ[0] != 5)
         begin failures++; $display("[TB] FAIL lw_cycles got=%0d exp=5", (rdCycQ.size() >= 3) ? rdCycQ[2] - rdCycQ[0] : -1); end
      checks++;
      if (rdCycQ.size() < 4 || rdCycQ[3] - rdCycQ[2] != 4)
         begin failures++; $display("[TB] FAIL sw_cycles got=%0d exp=4", (rdCycQ.size() >= 4) ? rdCycQ[3] - rdCycQ[2] : -1); end
      checks++;
      if (stDataQ.size() < 1 || stDataQ[0] !== 32'h0041_2022)
         begin failures++; $display("[TB] FAIL load_store got=%h exp=00412022", (stDataQ.size() > 0) ? stDataQ[0] : 32'h0); end
      checks++;
      if (mem[7'h50] !== 32'h0041_2022) begin failures++; $display("[TB] FAIL load_mem_commit got=%h exp=00412022", mem[7'h50]); end
   endtask

   task automatic test_branch_jump();
      logic [6:0]  expA [14];
      logic [31:0] expD [3];
      logic [6:0]  gotA;
      logic [31:0] got;
      expA = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h02, 7'h03, 7'h04, 7'h05,
               7'h10, 7'h20, 7'h21, 7'h11, 7'h12, 7'h13};
      expD = '{32'h11, 32'd2, 32'h11};
      hold_reset();
      mem[0]     = encI('h08, 0, 1, 1);
      mem[1]     = encI('h08, 0, 2, 0);
      mem[2]     = encI('h08, 2, 2, 1);
      mem[3]     = encI('h04, 2, 1, -2);
      mem[4]     = encI('h05, 2, 2, 5);
      mem[5]     = encJ('h02, 'h10);
      mem[7'h10] = encJ('h03, 'h20);
      mem[7'h11] = encI('h2B, 0, 2, 'h60);
      mem[7'h12] = encI('h2B, 0, 31, 'h61);
      mem[7'h13] = encJ('h02, 'h13);
      mem[7'h20] = encI('h2B, 0, 31, 'h62);
      mem[7'h21] = encR(31, 0, 0, 0, 'h08);
      release_reset();
      run_cycles(80);
      for (int i = 0; i < 14; i++) begin
         gotA = (i < rdAddrQ.size()) ? rdAddrQ[i] : 7'h7F;
         checks++;
         if (gotA !== expA[i]) begin failures++; $display("[TB] FAIL pc_seq%0d got=%h exp=%h", i, gotA, expA[i]); end
      end
      checks++;
      if (rdCycQ.size() < 5 || rdCycQ[4] - rdCycQ[3] != 3)
         begin failures++; $display("[TB] FAIL branch_cycles got=%0d exp=3", (rdCycQ.size() >= 5) ? rdCycQ[4] - rdCycQ[3] : -1); end
      for (int i = 0; i < 3; i++) begin
         got = (i < stDataQ.size()) ? stDataQ[i] : 32'hDEAD_0000;
         checks++;
         if (got !== expD[i]) begin failures++; $display("[TB] FAIL jal_store%0d got=%h exp=%h", i, got, expD[i]); end
      end
   endtask

   task automatic test_r0_nop();
      logic [31:0] expD [3];
      logic [31:0] got;
      expD = '{32'd0, 32'd0, 32'd7};
      hold_reset();
      mem[0] = encI('h2B, 0, 1, 'h73);
      mem[1] = encI('h08, 0, 0, 5);
      mem[2] = encI('h2B, 0, 0, 'h70);
      mem[3] = encI('h08, 0, 3, 7);
      mem[4] = 32'hFC63_0001;
      mem[5] = encR(3, 3, 3, 0, 'h21);
      mem[6] = encI('h2B, 0, 3, 'h71);
      mem[7] = encJ('h02, 7);
      release_reset();
      run_cycles(50);
      checks++;
      if (stDataQ.size() != 3) begin failures++; $display("[TB] FAIL nop_store_count got=%0d exp=3", stDataQ.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < stDataQ.size()) ? stDataQ[i] : 32'hDEAD_0000;
         checks++;
         if (got !== expD[i]) begin failures++; $display("[TB] FAIL r0_nop_store%0d got=%h exp=%h", i, got, expD[i]); end
      end
      checks++;
      if (rdCycQ.size() < 7 || rdAddrQ[5] !== 7'd5 || rdCycQ[5] - rdCycQ[4] != 3)
         begin failures++; $display("[TB] FAIL undef_op_cycles got=%0d exp=3", (rdCycQ.size() >= 6) ? rdCycQ[5] - rdCycQ[4] : -1); end
      checks++;
      if (rdCycQ.size() < 7 || rdAddrQ[6] !== 7'd6 || rdCycQ[6] - rdCycQ[5] != 3)
         begin failures++; $display("[TB] FAIL undef_funct_cycles got=%0d exp=3", (rdCycQ.size() >= 7) ? rdCycQ[6] - rdCycQ[5] : -1); end
   endtask

   task automatic test_mid_reset();
      hold_reset();
      mem[0]     = encI('h2B, 0, 0, 'h7F);
      mem[7'h7F] = 32'hDEAD_BEEF;
      release_reset();
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (WE !== 1'b1 || Address !== 7'h7F)
         begin failures++; $display("[TB] FAIL store_cycle got we=%b addr=%h exp we=1 addr=7f", WE, Address); end
      RST = 1'b1;
      #1;
      checks++;
      if (WE !== 1'b0 || CS !== 1'b0)
         begin failures++; $display("[TB] FAIL reset_masks_we got we=%b cs=%b exp 0 0", WE, CS); end
      @(posedge CLK);
      #1;
      checks++;
      if (mem[7'h7F] !== 32'hDEAD_BEEF)
         begin failures++; $display("[TB] FAIL reset_no_write got=%h exp=deadbeef", mem[7'h7F]); end
   endtask

   task automatic test_bus_hygiene();
      checks++;
      if (weGlitch != 0) begin failures++; $display("[TB] FAIL we_without_cs got=%0d exp=0", weGlitch); end
      checks++;
      if (busErr != 0) begin failures++; $display("[TB] FAIL bus_not_released got=%0d exp=0", busErr); end
   endtask

   initial begin
      $display("[TB] starting mips_multicycle_core bench");
      test_reset();
      test_alu();
      test_slt_shift();
      test_load();
      test_branch_jump();
      test_r0_nop();
      test_mid_reset();
      test_bus_hygiene();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
